// File: rtl/addr_sub_serial.sv
// Digit-serial two's-complement adder/subtractor with valid/ready handshake on both sides.
// DIGIT bits are summed per cycle through a small adder and a carry flop.
module addr_sub_serial #(
   parameter int unsigned WIDTH = 16,
   parameter int unsigned DIGIT = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             sub,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] result,
   output logic             carry,
   output logic             overflow,
   output logic             busy
);

   localparam int unsigned NDIG = WIDTH / DIGIT;
   localparam int unsigned CW   = (NDIG > 1) ? $clog2(NDIG) : 1;
   localparam logic [CW-1:0] LAST_DIG = CW'(NDIG - 1);

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_RUN  = 2'd1;
   localparam logic [1:0] S_DONE = 2'd2;

   logic [1:0]       r_state;
   logic [WIDTH-1:0] r_a;
   logic [WIDTH-1:0] r_b;
   logic [WIDTH-1:0] r_res;
   logic             r_cy;
   logic [CW-1:0]    r_cnt;
   logic             r_a_msb;
   logic             r_b_msb;
   logic             r_sub;
   logic [WIDTH-1:0] r_result;
   logic             r_carry;
   logic             r_ovf;

   logic             w_accept;
   logic [DIGIT:0]   w_sum;
   logic [WIDTH-1:0] w_dig_ext;
   logic [WIDTH-1:0] w_res_next;
   logic             w_ovf;

   assign in_ready  = (r_state == S_IDLE) || ((r_state == S_DONE) && out_ready);
   assign out_valid = (r_state == S_DONE);
   assign busy      = (r_state == S_RUN);
   assign result    = r_result;
   assign carry     = r_carry;
   assign overflow  = r_ovf;

   assign w_accept = in_valid && in_ready;

   assign w_sum      = {1'b0, r_a[DIGIT-1:0]} + {1'b0, r_b[DIGIT-1:0]} + (DIGIT+1)'(r_cy);
   assign w_dig_ext  = WIDTH'(w_sum[DIGIT-1:0]);
   // New digit enters at the top; after NDIG shifts the LSB digit sits at the bottom.
   assign w_res_next = (r_res >> DIGIT) | (w_dig_ext << (WIDTH - DIGIT));

   // b MSB is the pre-inversion copy, so add needs equal signs and sub needs differing signs.
   assign w_ovf = (r_sub ? (r_a_msb != r_b_msb) : (r_a_msb == r_b_msb)) &&
                  (w_res_next[WIDTH-1] != r_a_msb);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state  <= S_IDLE;
         r_a      <= '0;
         r_b      <= '0;
         r_res    <= '0;
         r_cy     <= 1'b0;
         r_cnt    <= '0;
         r_a_msb  <= 1'b0;
         r_b_msb  <= 1'b0;
         r_sub    <= 1'b0;
         r_result <= '0;
         r_carry  <= 1'b0;
         r_ovf    <= 1'b0;
      end else if (w_accept) begin
         r_state <= S_RUN;
         r_a     <= a;
         r_b     <= sub ? ~b : b;
         r_res   <= '0;
         r_cy    <= sub;
         r_cnt   <= '0;
         r_a_msb <= a[WIDTH-1];
         r_b_msb <= b[WIDTH-1];
         r_sub   <= sub;
      end else begin
         case (r_state)
            S_RUN: begin
               r_a   <= r_a >> DIGIT;
               r_b   <= r_b >> DIGIT;
               r_res <= w_res_next;
               r_cy  <= w_sum[DIGIT];
               r_cnt <= r_cnt + 1'b1;
               if (r_cnt == LAST_DIG) begin
                  r_state  <= S_DONE;
                  r_result <= w_res_next;
                  r_carry  <= w_sum[DIGIT];
                  r_ovf    <= w_ovf;
               end
            end
            S_DONE: begin
               if (out_ready) r_state <= S_IDLE;
            end
            S_IDLE: ;
            default: r_state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: doc/addr_sub_serial.md
# addr_sub_serial

Parametrised, digit-serial two's-complement adder/subtractor with a valid/ready handshake on both sides. It accepts one WIDTH-bit operand pair plus an add/sub mode, then processes DIGIT bits per clock through a small internal adder and carry flop. It returns the result, carry-out and signed overflow. It is the area-reduced successor to the combinational 4-bit adder/subtractor, for datapaths where wide operands arrive at low rate.

## Interface
- WIDTH, 16: operand and result width; must be an integer multiple of DIGIT.
- DIGIT, 4: bits processed per cycle; 1 ≤ DIGIT ≤ WIDTH; NDIG = WIDTH/DIGIT.
- clk  in  1  single clock, rising-edge.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  operand pair and mode present.
- in_ready  out  1  block can accept; combinational from state and out_ready.
- a  in  WIDTH  operand A.
- b  in  WIDTH  operand B.
- sub  in  1  0 = a+b, 1 = a−b, computed as a + ~b + 1.
- out_valid  out  1  result, carry and overflow valid.
- out_ready  in  1  consumer accepts the result.
- result  out  WIDTH  sum or difference, modulo 2^WIDTH.
- carry  out  1  raw carry-out of MSB; for sub, 1 = no borrow (a ≥ b unsigned).
- overflow  out  1  signed two's-complement overflow.
- busy  out  1  high in RUN state.

## Operation
- The FSM has three states: IDLE, RUN and DONE.
- IDLE:
  - in_ready = 1.
  - On in_valid & in_ready, latch a, (sub ? ~b : b) and sub into shift registers.
  - Preset the carry flop to sub, clear the digit counter and go to RUN.
- RUN:
  - Each cycle, add the low DIGIT bits of both shift registers plus the carry flop.
  - Shift the DIGIT-bit sum into the top of the result shift register, update the carry flop and shift both operands right by DIGIT.
  - Increment the counter.
  - After the NDIG-th digit, go to DONE.
- Completion edge (RUN→DONE):
  - result ← full result shift register; carry ← final carry.
  - overflow: add gives a[MSB]==b[MSB] && result[MSB]!=a[MSB]; sub gives a[MSB]!=b[MSB] && result[MSB]!=a[MSB].
  - Use the latched copy of a[MSB], and b[MSB] as latched before inversion.
- DONE:
  - out_valid = 1; result, carry and overflow are held stable.
  - in_ready = out_ready.
  - out_valid & out_ready without a new input: go to IDLE.
  - out_valid & out_ready with in_valid in the same cycle: accept the new operands and go directly to RUN, with no bubble.
- result, carry and overflow change only on completion edges or reset. Between operations they hold the last values, qualified by out_valid.
- Inputs a, b and sub are sampled only on the accept edge; later changes are ignored.

## Timing
- Reset (asynchronous, immediate) sets state IDLE and counter 0, and clears all internal registers.
- Output values during and after reset: out_valid 0, busy 0, in_ready 1, result 0, carry 0, overflow 0.
- Latency: operands accepted at edge k give out_valid = 1 after edge k+NDIG. With NDIG = 1, out_valid rises one cycle after accept.
- Throughput: with out_ready tied high and in_valid continuous, one result every NDIG cycles.
- Backpressure: out_ready low in DONE holds all outputs for any duration; in_ready = 0, and in_valid is ignored.
- in_ready is 0 throughout RUN; busy is 1 only in RUN.
- Reset asserted mid-RUN or in DONE aborts the operation with no partial output.
- The first accept after reset release behaves normally.

## Test plan
All scenarios use WIDTH=16, DIGIT=4 (NDIG=4) unless noted.
- Add, basic: a=0x1234, b=0x0FFF, sub=0 → result 0x2233, carry 0, overflow 0. out_valid rises exactly 4 cycles after accept; busy is high for 4 cycles.
- Add, boundaries:
  - 0xFFFF+0x0001 → 0x0000, carry 1, ovf 0.
  - 0x7FFF+0x0001 → 0x8000, carry 0, ovf 1.
- Subtract, boundaries:
  - 0x0005−0x0007 → 0xFFFE, carry 0, ovf 0.
  - 0x8000−0x0001 → 0x7FFF, carry 1, ovf 1.
  - 0x1234−0x1234 → 0x0000, carry 1, ovf 0.
- Backpressure and back-to-back:
  - Hold out_ready=0 for 10 cycles in DONE while in_valid=1 and a changes: outputs stable, in_ready 0, no accept.
  - Then raise out_ready with in_valid=1: new pair accepted on the same edge, next out_valid 4 cycles later.
- Reset mid-operation: assert rst on the 2nd RUN cycle → out_valid 0, busy 0, in_ready 1 and result 0 immediately. The next op, 0x0001+0x0002, gives 0x0003.
- Parameter sweep:
  - Rerun all vectors with DIGIT=1 (latency 16) and DIGIT=16 (latency 1).
  - Run 1000 random ops per configuration against a + (sub ? ~b+1 : b) reference, checking result, carry and overflow.
